// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pkg : shared types and constants for the instruction prefetch queue
// Revision   : 1.0
// ============================================================================
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// ifetch_fifo : DEPTH-entry FIFO of fetched {instr, pc4} pairs, head read combinationally
// Revision    : 1.0
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle makes room, so a full FIFO may still accept a push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!clear && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// ifetch_queue : sequential instruction prefetch with one request in flight and redirect flush
// Revision     : 1.0
// ============================================================================
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t   state;
    fetch_state_t   state_nx;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_nx;
    logic [CW-1:0]  count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [CW:0]    occ_idle;
    logic [CW:0]    occ_wait;
    logic           credit_idle;
    logic           credit_wait;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           unused_bits;

    assign pop  = out_ready && !fifo_empty && !redirect;
    assign push = (state == WAIT) && imem_rvalid && !redirect;

    // fetch_pc already advanced past the outstanding request, so it is that request's PC+4.
    assign push_entry = '{instr: imem_rdata, pc4: fetch_pc};

    // Occupancy after this cycle's pop (and push, when the response lands now).
    assign occ_idle    = {1'b0, count} - {{CW{1'b0}}, pop};
    assign occ_wait    = {1'b0, count} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};
    assign credit_idle = (occ_idle < DEPTH_W);
    assign credit_wait = (occ_wait < DEPTH_W);

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        if (redirect) begin
            fetch_pc_nx = {redirect_pc[31:2], 2'b00};
            case (state)
                IDLE:    state_nx = REQ;
                REQ:     state_nx = imem_ready  ? DROP : REQ;
                WAIT:    state_nx = imem_rvalid ? REQ  : DROP;
                DROP:    state_nx = imem_rvalid ? REQ  : DROP;
                default: state_nx = REQ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (credit_idle) begin
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        state_nx    = WAIT;
                        fetch_pc_nx = fetch_pc + PC_STEP;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_nx = credit_wait ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_nx = REQ;
                    end
                end
                default: state_nx = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            imem_req <= 1'b1;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            imem_req <= (state_nx == REQ);
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign imem_addr = fetch_pc;
    assign out_valid = !fifo_empty;
    assign out_instr = head.instr;
    assign out_pc4   = head.pc4;

    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue. Sits between a multi-cycle instruction memory port and the decode stage of the five-stage CPU. It issues sequential fetches with a single request in flight and buffers returned instructions, each paired with its PC+4, in a small FIFO. It presents them to decode under a valid/ready handshake. Branch and jump redirects from the MEM stage flush the queue, discard the in-flight response and restart fetch at the target.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000: first fetch address after reset

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch byte address, word aligned
- `imem_ready`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `out_valid`  out  1  head entry valid
- `out_instr`  out  32  head instruction
- `out_pc4`  out  32  head PC+4
- `out_ready`  in  1  decode consumes head; low = stall
- `redirect`  in  1  flush and restart fetch; single-cycle pulse or held
- `redirect_pc`  in  32  restart address; bits [1:0] ignored and forced to 0

## Operation
Registers:
- `fetch_pc`: next address to fetch
- `state`: one of IDLE, REQ, WAIT, DROP
- FIFO: write pointer, read pointer, count (0..DEPTH)

Credit rule:
- A request may issue only if count plus in-flight requests (0 or 1) is below DEPTH.
- A dequeue in the same cycle frees its slot for this decision.

State machine (no redirect):
- IDLE → REQ when credit is available.
- REQ:
  - `imem_req`=1, `imem_addr`=`fetch_pc`.
  - Address is held stable until accepted.
  - On `imem_ready`: move to WAIT, `fetch_pc` += 4.
- WAIT, on `imem_rvalid`:
  - Push {`imem_rdata`, request address + 4}.
  - Go to REQ if credit is available, otherwise IDLE.
- DROP, on `imem_rvalid`: discard the data and go to REQ.
- `imem_rvalid` in IDLE or REQ is ignored.

Redirect, which takes priority over every other event in the cycle:
- Count, read pointer and write pointer are cleared; a simultaneous pop or push is suppressed.
- `fetch_pc` is loaded with `redirect_pc`.
- State transition:
  - IDLE → REQ
  - REQ with `imem_ready`=0 → REQ (address changes next cycle)
  - REQ with `imem_ready`=1 → DROP (the old-address request was accepted)
  - WAIT with `imem_rvalid`=0 → DROP
  - WAIT with `imem_rvalid`=1 → REQ (response discarded)
  - DROP stays DROP, unless `imem_rvalid`=1, in which case → REQ.

FIFO:
- Head is read combinationally: `out_valid` = (count≠0).
- Push and pop in the same cycle leave count unchanged. This is legal even when the FIFO is full.
- Pointers wrap modulo DEPTH.
- Arithmetic is 32-bit unsigned; PC wrap from 32'hFFFF_FFFC to 0 is permitted.

## Timing
Reset values:
- state=REQ, `fetch_pc`=`RESET_PC`, count=0.
- Outputs: `imem_req`=1, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc4`=0.

Reset behaviour:
- Reset is asynchronous on assertion; the first request is issued in the first cycle after deassertion.
- Reset mid-transaction abandons the in-flight response. Any late `imem_rvalid` lands in REQ and is ignored.

Latency:
- Request accepted at edge N, `imem_rvalid` in cycle M>N: entry is written at edge M and `out_valid`=1 in cycle M+1.
- The next request is asserted in cycle M+1.
- `imem_req` and `out_*` are functions of registered state only, with no combinational path from `imem_ready` or `out_ready`.
- Redirect asserted in cycle R: `out_valid`=0 in R+1 and `imem_addr`=`redirect_pc` in R+1 (REQ case).

## Structure
- Package `ifetch_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, WAIT, DROP}
  - `fetch_entry_t` packed struct {instr[31:0], pc4[31:0]}
  - constant `PC_STEP` = 4
- Sub-module `ifetch_fifo`: `DEPTH` × `fetch_entry_t` storage with push, pop, clear, count, full and empty.
- The fetch FSM, credit logic and redirect handling stay in `ifetch_queue`.

## Test plan
- Reset release, with `imem_ready`=1 and 1-cycle `rvalid` latency, `out_ready`=1: addresses 0,4,8 are issued in order; outputs are (instr@0, pc4=4), (instr@4, pc4=8) with one entry per two cycles.
- `out_ready`=0 with DEPTH=4: exactly 4 requests are issued, then `imem_req`=0 and `out_valid`=1. Raising `out_ready` for one cycle issues exactly one new request.
- Redirect to 32'h40 while in WAIT: the pending response is dropped and the next request address is 32'h40. The first output has pc4=32'h44, with no stale entry.
- Redirect to 32'h80 in the same cycle as `imem_ready`=1 in REQ: state → DROP, the following `rvalid` is discarded, then 32'h80 is fetched.
- Full FIFO with simultaneous `rvalid` and pop: count stays 4 and order is preserved across pointer wrap.
- `rst_n` asserted mid-WAIT, then a stray `rvalid` after release: it is ignored, `out_valid` stays 0 and the first fetch is at `RESET_PC`.
